// File: rtl/ifu_fetch_buf.sv
// Instruction fetch buffer: reads 64-bit ITCM lines, splits them into two 32-bit
// instructions with their PCs, and hands them to decode over a valid/ready handshake.
module ifu_fetch_buf #(
  parameter int ITCM_AW = 11,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     cpurst_n,
  input  logic [31:0]              boot_addr,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     itcm_cs,
  output logic [ITCM_AW-1:0]       itcm_addr,
  input  logic [63:0]              itcm_rdata,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  output logic                     dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_count
);

  // Handshake: the head entry transfers on any rising edge where inst_valid and
  // inst_ready are both high; inst/inst_pc hold until that transfer happens.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] OCC_MAX = (CW+1)'(DEPTH - 2);

  typedef enum logic {S_BOOT = 1'b0, S_RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q;
  logic            inflight_q;
  logic            resp_odd_q;
  logic [28:0]     resp_line_q;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q, wr_ptr_p1;
  logic [CW-1:0]   count_q;
  logic [31:0]     mem_inst [DEPTH];
  logic [31:0]     mem_pc   [DEPTH];

  logic            issue, flush, resp, pop;
  logic [1:0]      push_n;
  logic [CW:0]     occ;

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) state_q <= S_BOOT;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_BOOT) state_d = S_RUN;
  end

  // Each outstanding read reserves two slots so a response can never overflow.
  always_comb begin
    occ        = {1'b0, count_q} + {{(CW-1){1'b0}}, inflight_q, 1'b0};
    flush      = (state_q == S_RUN) && redirect_valid;
    issue      = (state_q == S_RUN) && !redirect_valid && (occ <= OCC_MAX);
    resp       = inflight_q && !flush;
    pop        = (count_q != '0) && inst_ready && !flush;
    push_n     = resp ? (resp_odd_q ? 2'd1 : 2'd2) : 2'd0;
    wr_ptr_p1  = wr_ptr_q + PW'(1);
    itcm_cs    = issue;
    itcm_addr  = fetch_pc_q[ITCM_AW+2:3];
    inst_valid = (count_q != '0);
    inst       = mem_inst[rd_ptr_q];
    inst_pc    = mem_pc[rd_ptr_q];
    dbg_state  = state_q;
    dbg_count  = count_q;
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      fetch_pc_q  <= '0;
      inflight_q  <= 1'b0;
      resp_odd_q  <= 1'b0;
      resp_line_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else begin
      if (state_q == S_BOOT)   fetch_pc_q <= boot_addr & 32'hFFFF_FFFC;
      else if (redirect_valid) fetch_pc_q <= redirect_pc & 32'hFFFF_FFFC;
      else if (issue)          fetch_pc_q <= (fetch_pc_q & 32'hFFFF_FFF8) + 32'd8;

      inflight_q <= issue;
      if (issue) begin
        resp_odd_q  <= fetch_pc_q[2];
        resp_line_q <= fetch_pc_q[31:3];
      end

      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (resp) begin
          // An odd-word entry point skips the lower half of the first line.
          if (resp_odd_q) begin
            mem_inst[wr_ptr_q] <= itcm_rdata[63:32];
            mem_pc[wr_ptr_q]   <= {resp_line_q, 3'b100};
            wr_ptr_q           <= wr_ptr_p1;
          end else begin
            mem_inst[wr_ptr_q]  <= itcm_rdata[31:0];
            mem_pc[wr_ptr_q]    <= {resp_line_q, 3'b000};
            mem_inst[wr_ptr_p1] <= itcm_rdata[63:32];
            mem_pc[wr_ptr_p1]   <= {resp_line_q, 3'b100};
            wr_ptr_q            <= wr_ptr_q + PW'(2);
          end
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(push_n) - CW'(pop);
      end
    end
  end

endmodule

// File: doc/ifu_fetch_buf.md
# ifu_fetch_buf

Instruction fetch front end that sits directly downstream of the ITCM (isram) inside `top`. It reads 64-bit ITCM lines, splits each line into two 32-bit instructions, and queues them in a small FIFO. It presents the instructions one at a time, with their PC, to the decode stage through a valid/ready handshake. It starts at `boot_addr` after reset and restarts at a new PC on a redirect (branch, jump, or trap), discarding stale instructions.

## Interface
- `ITCM_AW`, 11: ITCM word-address width (2048 × 64-bit = 16 KiB).
- `DEPTH`, 4: instruction FIFO entries. Must be a power of two, ≥ 4.

- `clk`  in  1  core clock, all state on rising edge.
- `cpurst_n`  in  1  asynchronous active-low reset.
- `boot_addr`  in  32  reset PC; sampled once in BOOT state.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored (treated as 0).
- `itcm_cs`  out  1  ITCM read strobe.
- `itcm_addr`  out  ITCM_AW  ITCM word address = pc[ITCM_AW+2:3].
- `itcm_rdata`  in  64  read data; valid the cycle after `itcm_cs`. Bits [31:0] = lower address.
- `inst_valid`  out  1  FIFO head valid.
- `inst_ready`  in  1  decode accepts head.
- `inst`  out  32  head instruction.
- `inst_pc`  out  32  head PC.

## Operation
- **States**
  - BOOT is the reset state. Next cycle: `fetch_pc <= {boot_addr[31:2],2'b00}`, then go to RUN.
  - RUN is the only other state. No return to BOOT except through reset.
- **Issue**
  - In RUN, `itcm_cs=1` when `count + 2*inflight <= DEPTH-2` and `redirect_valid=0`.
  - `inflight` is the 1-bit flag for a read issued last cycle.
  - On issue: `fetch_pc <= {fetch_pc[31:3],3'b000} + 8`, wrapping from 0xFFFFFFF8 to 0.
  - The ITCM address wraps modulo the ITCM size. There is no fault.
- **Response**
  - The cycle after an issue, the response pushes the lower word (PC = line base) and then the upper word (PC = base+4).
  - If the request PC had bit[2]=1 (first fetch after an odd-word boot or redirect), only the upper word is pushed.
  - The request PC[2] is held in a register alongside `inflight`.
- **Pop**
  - `inst_valid && inst_ready` pops the head.
  - Push and pop in the same cycle are both applied, and `count` updates by the net amount.
- **Redirect** (priority over everything)
  - Clears the FIFO (`count=0`) and kills any in-flight response: it is not pushed.
  - Sets `fetch_pc <= redirect_pc`. No issue happens in the redirect cycle.
  - A pop in the same cycle is ignored; the entry is flushed, not consumed.
  - `redirect_valid` in BOOT is ignored.
- **FIFO**: circular buffer with rd/wr pointers of `$clog2(DEPTH)` bits and `count` of `$clog2(DEPTH)+1` bits. Pointers wrap naturally. The issue rule guarantees the FIFO never overflows.

## Timing
- **Reset values**: state=BOOT, `itcm_cs=0`, `itcm_addr=0`, `inst_valid=0`, `inst=0`, `inst_pc=0`, `count=0`, `inflight=0`, `fetch_pc=0`.
- **Output timing**: `itcm_cs` and `itcm_addr` are combinational from registered state. `inst`, `inst_pc` and `inst_valid` are driven from the registered FIFO head.
- **From reset**: reset deasserted before edge 0. Edge 0: BOOT→RUN. Cycle 1: `itcm_cs`. Cycle 2: `itcm_rdata` valid, pushed at edge 2. Cycle 3: `inst_valid=1` with `inst_pc=boot_addr`. Latency is 3 cycles.
- **From redirect**: `redirect_valid` in cycle N. `inst_valid=0` in N+1. `itcm_cs` with the new address in N+1. First new instruction valid in N+3.
- **Async reset mid-operation**: all state clears immediately. Partially fetched data is dropped and the BOOT sequence repeats.
- **Back-pressure**: with `inst_ready=0`, fetch stops once `count + 2*inflight > DEPTH-2`. `inst`/`inst_pc` hold stable while `inst_valid=1` and not popped.

## Test plan
- **Boot at 0**: ITCM line0 = 0x00000013_00100093, `boot_addr=0`, `inst_ready=1`.
  - Cycle 3: `inst=0x00100093`, `inst_pc=0`.
  - Cycle 4: `inst=0x00000013`, `inst_pc=4`.
  - Sequential PCs continue 8, 12, ….
- **Odd-word boot**: `boot_addr=0x4`.
  - First instruction is the upper half of line0 with `inst_pc=0x4`.
  - Next is line1 lower with `inst_pc=0x8`. No instruction with `inst_pc=0x0` ever appears.
- **Stall**: `inst_ready=0` from reset.
  - `count` reaches exactly DEPTH (4), then `itcm_cs` stays 0.
  - Head holds `inst_pc=0`. Release `inst_ready`: PCs 0,4,8,12,16,… arrive in order, none lost or duplicated.
- **Redirect with in-flight read**: `redirect_valid=1`, `redirect_pc=0x100` in the cycle after an issue, while `inst_ready=1`.
  - No instruction from the killed line appears.
  - `inst_valid=0` for cycles N+1 and N+2. `inst_pc=0x100` in N+3.
- **Redirect + pop same cycle, and back-to-back redirects**:
  - The pop is ignored and the FIFO is emptied.
  - Redirects to 0x20 then 0x40 on consecutive cycles: the first delivered `inst_pc` is 0x40.
- **Wrap and reset mid-run**:
  - `redirect_pc=0x3FF8` (ITCM_AW=11): lines 2047 then 0 are read, PCs 0x3FF8, 0x3FFC, 0x4000, with `itcm_addr` 2047 then 0.
  - Assert `cpurst_n=0` mid-stream: `inst_valid` drops asynchronously and the sequence restarts at `boot_addr`.
